mem_responder: RTL and testbench

- Multicycle word-memory responder; the target end of the memory interface driven by the multicycle MIPS controller/datapath.
- Accepts one read or write request at a time with a req/ready handshake.
- Inserts a configurable number of wait states, then returns read data or commits write data and pulses ready.
- Flags misaligned and out-of-range accesses so the controller's memory stages can be exercised with realistic latency.

---
 rtl/mem_responder_if.sv | 23 ++
 rtl/mem_responder.sv | 115 +++++++++++
 tb/tb_mem_responder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Memory request/response bus between the multicycle controller (master)
// and the word-memory responder (slave).
interface mem_responder_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        err;
   logic        busy;
   logic [1:0]  state;

   modport master (
      output req, we, addr, wdata,
      input  rdata, ready, err, busy, state
   );

   modport slave (
      input  req, we, addr, wdata,
      output rdata, ready, err, busy, state
   );
endinterface

// File: rtl/mem_responder.sv
// Multicycle word-memory responder: accepts one request at a time, inserts
// WAIT_CYCLES wait states, then pulses ready with read data or commits the
// write. Misaligned and out-of-range accesses raise err and touch nothing.
module mem_responder #(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input logic           clk,
   input logic           rst,
   mem_responder_if.slave bus
);

   localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD  = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
   localparam logic [29:0]   DEPTH_IDX = 30'(DEPTH_WORDS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          lat_we_q;
   logic [31:0]   lat_addr_q, lat_wdata_q;
   logic          ready_q, err_q;
   logic [31:0]   rdata_q, rdata_d;
   logic [31:0]   mem [DEPTH_WORDS];

   logic          cur_we, cur_err;
   logic [31:0]   cur_addr, cur_wdata;
   logic [IW-1:0] cur_idx;
   logic          enter_resp, mem_wr;

   // Effective request: live bus in IDLE (covers the zero-wait path where
   // RESP is entered on the acceptance edge), latched copy otherwise.
   always_comb begin
      cur_we    = (state_q == S_IDLE) ? bus.we    : lat_we_q;
      cur_addr  = (state_q == S_IDLE) ? bus.addr  : lat_addr_q;
      cur_wdata = (state_q == S_IDLE) ? bus.wdata : lat_wdata_q;
      cur_err   = (cur_addr[1:0] != 2'b00) || (cur_addr[31:2] >= DEPTH_IDX);
      cur_idx   = cur_addr[IW+1:2];
   end

   // Next-state, wait counter and response data for the RESP entry edge.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      enter_resp = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.req) begin
               if (WAIT_CYCLES == 0) begin
                  state_d    = S_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d    = S_RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      mem_wr  = enter_resp && cur_we && !cur_err;
      rdata_d = (enter_resp && !cur_we && !cur_err) ? mem[cur_idx] : '0;
   end

   // State, request latch and registered response outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         lat_we_q    <= 1'b0;
         lat_addr_q  <= '0;
         lat_wdata_q <= '0;
         ready_q     <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == S_IDLE && bus.req) begin
            lat_we_q    <= bus.we;
            lat_addr_q  <= bus.addr;
            lat_wdata_q <= bus.wdata;
         end
         ready_q <= enter_resp;
         err_q   <= enter_resp && cur_err;
         rdata_q <= rdata_d;
      end
   end

   // Storage is not reset; a write held off by reset never commits.
   always_ff @(posedge clk) begin
      if (rst && mem_wr) mem[cur_idx] <= cur_wdata;
   end

   assign bus.ready = ready_q;
   assign bus.err   = err_q;
   assign bus.rdata = rdata_q;
   assign bus.busy  = (state_q != S_IDLE);
   assign bus.state = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_CYCLES=2 instance and a
// zero-wait instance on a shared clock and reset.
module tb_mem_responder;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   mem_responder_if b  ();
   mem_responder_if b0 ();

   mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (b.slave)
   );

   mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (b0.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request, count edges from acceptance to ready (acceptance edge = 1),
   // check the response cycle and the IDLE cycle that follows.
   task automatic txn(virtual mem_responder_if vif, input string tag,
                      input logic w, input logic [31:0] a, input logic [31:0] d,
                      input int exp_lat, input logic exp_err, input logic [31:0] exp_rd);
      int n;
      vif.req = 1'b1; vif.we = w; vif.addr = a; vif.wdata = d;
      tick();
      n = 1;
      while (!vif.ready && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_ready"}, 32'(vif.ready), 32'd1);
      chk({tag, "_lat"},   32'(n), 32'(exp_lat));
      chk({tag, "_err"},   32'(vif.err), 32'(exp_err));
      chk({tag, "_rdata"}, vif.rdata, exp_rd);
      chk({tag, "_busy"},  32'(vif.busy), 32'd1);
      chk({tag, "_state"}, 32'(vif.state), 32'd2);
      vif.req = 1'b0;
      tick();
      chk({tag, "_rdy0"},  32'(vif.ready), 32'd0);
      chk({tag, "_rd0"},   vif.rdata, 32'd0);
      chk({tag, "_err0"},  32'(vif.err), 32'd0);
      chk({tag, "_idle"},  32'(vif.state), 32'd0);
   endtask

   initial begin
      int  n;
      bit  saw_ready;
      checks = 0;
      errors = 0;
      rst = 1'b0;
      b.req = 1'b0;  b.we = 1'b0;  b.addr = '0;  b.wdata = '0;
      b0.req = 1'b0; b0.we = 1'b0; b0.addr = '0; b0.wdata = '0;
      tick();
      tick();
      chk("rst_state", 32'(b.state), 32'd0);
      chk("rst_busy",  32'(b.busy), 32'd0);
      chk("rst_ready", 32'(b.ready), 32'd0);
      chk("rst_err",   32'(b.err), 32'd0);
      chk("rst_rdata", b.rdata, 32'd0);
      rst = 1'b1;
      tick();

      // Basic write/read, 3-edge latency with two wait states
      txn(b, "wr10", 1'b1, 32'h10, 32'hDEADBEEF, 3, 1'b0, 32'h0);
      txn(b, "rd10", 1'b0, 32'h10, 32'h0, 3, 1'b0, 32'hDEADBEEF);

      // Misaligned write must not touch word 4
      txn(b, "wr12", 1'b1, 32'h12, 32'h1, 3, 1'b1, 32'h0);
      txn(b, "rd10b", 1'b0, 32'h10, 32'h0, 3, 1'b0, 32'hDEADBEEF);

      // Range boundary: index 64 errors, index 63 is valid
      txn(b, "rd100", 1'b0, 32'h100, 32'h0, 3, 1'b1, 32'h0);
      txn(b, "wrFC", 1'b1, 32'hFC, 32'h12345678, 3, 1'b0, 32'h0);
      txn(b, "rdFC", 1'b0, 32'hFC, 32'h0, 3, 1'b0, 32'h12345678);
      txn(b, "rdhi", 1'b0, 32'h8000_0010, 32'h0, 3, 1'b1, 32'h0);

      // Back-to-back with req held through ready
      b.req = 1'b1; b.we = 1'b1; b.addr = 32'h4; b.wdata = 32'h11111111;
      tick();
      n = 1;
      while (!b.ready && n < 20) begin tick(); n++; end
      chk("b2b_wr_lat", 32'(n), 32'd3);
      chk("b2b_wr_err", 32'(b.err), 32'd0);
      b.we = 1'b0; b.wdata = '0;
      tick();
      chk("b2b_gap_busy",  32'(b.busy), 32'd0);
      chk("b2b_gap_ready", 32'(b.ready), 32'd0);
      tick();
      chk("b2b_acc_busy",  32'(b.busy), 32'd1);
      chk("b2b_acc_state", 32'(b.state), 32'd1);
      n = 1;
      while (!b.ready && n < 20) begin tick(); n++; end
      chk("b2b_rd_lat",   32'(n), 32'd3);
      chk("b2b_rd_rdata", b.rdata, 32'h11111111);
      b.req = 1'b0;
      tick();
      chk("b2b_end_busy", 32'(b.busy), 32'd0);

      // Reset during WAIT discards the pending write
      txn(b, "wr8", 1'b1, 32'h8, 32'h55AA55AA, 3, 1'b0, 32'h0);
      b.req = 1'b1; b.we = 1'b1; b.addr = 32'h8; b.wdata = 32'hCAFEF00D;
      tick();
      chk("abort_wait", 32'(b.state), 32'd1);
      b.req = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("abort_state", 32'(b.state), 32'd0);
      chk("abort_busy",  32'(b.busy), 32'd0);
      tick();
      rst = 1'b1;
      saw_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (b.ready) saw_ready = 1'b1;
      end
      chk("abort_noready", 32'(saw_ready), 32'd0);
      txn(b, "rd8", 1'b0, 32'h8, 32'h0, 3, 1'b0, 32'h55AA55AA);

      // Zero-wait instance: RESP on the acceptance edge, IDLE on the next
      txn(b0, "z_wr", 1'b1, 32'h20, 32'h0BADCAFE, 1, 1'b0, 32'h0);
      b0.req = 1'b1; b0.we = 1'b0; b0.addr = 32'h20;
      chk("z_pre_state", 32'(b0.state), 32'd0);
      tick();
      chk("z_acc_state", 32'(b0.state), 32'd2);
      chk("z_acc_ready", 32'(b0.ready), 32'd1);
      chk("z_acc_rdata", b0.rdata, 32'h0BADCAFE);
      b0.req = 1'b0;
      tick();
      chk("z_end_state", 32'(b0.state), 32'd0);
      chk("z_end_ready", 32'(b0.ready), 32'd0);
      txn(b0, "z_mis", 1'b0, 32'h21, 32'h0, 1, 1'b1, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
